satatrn_rxarb: RTL and testbench
================================

# satatrn_rxarb

Receive-side FIS router for the SATA transport layer, the mirror of the transmit arbiter. It accepts the received FIS stream from the link layer in the PHY clock domain, classifies each FIS by the type byte in its first word, and routes it to one of two outputs:
- DATA FIS (0x46): header word stripped; payload goes to the data stream, length-checked.
- Every other FIS: passed whole to the register stream, which the transport layer carries to the bus clock.

## Interface
- LGMAXDATA, 11: log2 of maximum DATA FIS payload in 32-bit words (2048).
- OPT_LOWPOWER, 1'b0: when set, o_*_data/o_*_last/o_*_err are forced to zero whenever the matching o_*_valid is low.
- i_phy_clk  input  1  sole clock; everything in this block is in this domain.
- i_phy_reset_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  received FIS word valid.
- o_ready  output  1  received word accepted this cycle.
- i_data  input  32  received FIS word; first word of a FIS carries the type in [7:0].
- i_last  input  1  final word of FIS.
- i_err  input  1  link-layer CRC/decode error, qualified on the i_last beat only.
- o_reg_valid  output  1  register-stream word valid.
- i_reg_ready  input  1  register-stream sink ready.
- o_reg_data  output  32  register-stream word (full FIS, header included).
- o_reg_last  output  1  final word of register FIS.
- o_reg_err  output  1  error flag, meaningful on o_reg_last beat.
- o_data_valid  output  1  data payload word valid.
- i_data_ready  input  1  data sink ready.
- o_data_data  output  32  payload word.
- o_data_last  output  1  final payload word.
- o_data_err  output  1  error flag, meaningful on o_data_last beat.
- o_drop  output  1  one-cycle pulse: a FIS or FIS tail was discarded.

## Operation
- States: IDLE, REG, DATA, DROP. Reset: IDLE; all outputs 0.
- Output registers:
  - Each output stream is one registered stage.
  - A stage may load when !o_x_valid || i_x_ready.
  - A stage clears o_x_valid when it is accepted and nothing new loads.
- IDLE, i_valid, i_data[7:0]==0x46:
  - Header word is absorbed with o_ready=1 regardless of output state.
  - Word counter is cleared.
  - If i_last is set (zero-payload DATA FIS): pulse o_drop and stay in IDLE. Otherwise go to DATA.
- IDLE, i_valid, any other type:
  - o_ready = register stage may load.
  - On accept, the word is loaded with last=i_last and err=i_last&&i_err.
  - Go to REG if !i_last.
- REG:
  - o_ready = register stage may load.
  - Each word is forwarded.
  - Return to IDLE on the accepted i_last.
- DATA:
  - o_ready = data stage may load.
  - Each accepted word is forwarded and the counter increments; the counter is LGMAXDATA+1 bits.
  - On i_last: load last=1, err=i_err, go to IDLE.
  - On the 2^LGMAXDATA-th word without i_last: load last=1, err=1, go to DROP.
- DROP:
  - o_ready=1; words are discarded.
  - On the accepted i_last: pulse o_drop, go to IDLE.
- Never drive both o_reg_valid and o_data_valid from the same input beat.
- Reset mid-FIS: immediate return to IDLE; all valids cleared. The tail of the interrupted FIS is then classified as a new FIS; upstream must also be reset.

## Timing
- Latency: accepted input word appears on the selected output the next cycle.
- Throughput: one word per cycle per stream while the sink holds ready high.
- o_ready is combinational from state, i_data[7:0] (IDLE only), and output stage status. It never depends on i_valid.
- Back-pressure on one stream never stalls draining of the other stage's already-registered word.
- Header absorption costs one input cycle and produces no output beat.
- o_drop is asserted the cycle after the triggering accept and is 1 cycle wide.

## Test plan
- Register FIS, 5 words, type 0x34, sinks always ready:
  - 5 o_reg beats, word 0 = input word 0, o_reg_last on beat 5, o_reg_err=0.
  - o_data_valid never asserted.
- DATA FIS, header 0x00000046 plus 4 payload words 0xA0..0xA3, i_err=1 on last:
  - o_data emits 0xA0..0xA3, last and err on 0xA3.
  - No register output.
- Zero-payload DATA FIS (single word 0x46, i_last=1):
  - No output valid.
  - o_drop pulses once.
  - The next FIS is routed normally.
- DATA FIS with 2050 payload words:
  - Exactly 2048 data beats; beat 2048 carries last=1, err=1.
  - Remaining 2 words accepted and discarded; o_drop pulses on the final one.
- Back-pressure: i_data_ready toggling 1/0 every cycle during an 8-word DATA payload:
  - All 8 words delivered in order, no duplicates or losses.
  - o_ready low exactly while the data stage is full and unaccepted.
- Async reset asserted mid-REG after word 2 of 6:
  - All valids drop with reset.
  - After release, a fresh 3-word register FIS is delivered intact.

Source files
------------

// File: rtl/satatrn_rxarb.sv
// Receive-side SATA transport FIS router: DATA FIS payloads go to the data stream
// with the header stripped and the length bounded; every other FIS goes whole to the register stream.
module satatrn_rxarb #(
    parameter int LGMAXDATA    = 11,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic        i_phy_clk,
    input  logic        i_phy_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data,
    input  logic        i_last,
    input  logic        i_err,
    output logic        o_reg_valid,
    input  logic        i_reg_ready,
    output logic [31:0] o_reg_data,
    output logic        o_reg_last,
    output logic        o_reg_err,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic [31:0] o_data_data,
    output logic        o_data_last,
    output logic        o_data_err,
    output logic        o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REG  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [LGMAXDATA:0] MAX_WORDS = {1'b1, {LGMAXDATA{1'b0}}};

    state_t               state_q, state_d;
    logic [LGMAXDATA:0]   cnt_q, cnt_d;
    logic                 drop_q, drop_d;
    logic                 reg_valid_q, reg_last_q, reg_err_q;
    logic [31:0]          reg_data_q;
    logic                 data_valid_q, data_last_q, data_err_q;
    logic [31:0]          data_data_q;
    logic                 reg_can_s, data_can_s, is_hdr_s;
    logic                 reg_ld_s, reg_last_s, reg_err_s;
    logic                 data_ld_s, data_last_s, data_err_s;
    logic                 ready_s;
    logic [LGMAXDATA:0]   cnt_inc_s;

    assign reg_can_s  = !reg_valid_q || i_reg_ready;
    assign data_can_s = !data_valid_q || i_data_ready;
    assign is_hdr_s   = (i_data[7:0] == 8'h46);
    assign cnt_inc_s  = cnt_q + {{LGMAXDATA{1'b0}}, 1'b1};

    // Next-state, input handshake and output-stage load decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = 1'b0;
        ready_s     = 1'b0;
        reg_ld_s    = 1'b0;
        reg_last_s  = 1'b0;
        reg_err_s   = 1'b0;
        data_ld_s   = 1'b0;
        data_last_s = 1'b0;
        data_err_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_hdr_s) begin
                    // Header is always absorbed; it never needs an output slot.
                    ready_s = 1'b1;
                    if (i_valid) begin
                        cnt_d = {(LGMAXDATA+1){1'b0}};
                        if (i_last) begin
                            drop_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    ready_s = reg_can_s;
                    if (i_valid && reg_can_s) begin
                        reg_ld_s   = 1'b1;
                        reg_last_s = i_last;
                        reg_err_s  = i_last && i_err;
                        state_d    = i_last ? ST_IDLE : ST_REG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REG: begin
                ready_s = reg_can_s;
                if (i_valid && reg_can_s) begin
                    reg_ld_s   = 1'b1;
                    reg_last_s = i_last;
                    reg_err_s  = i_last && i_err;
                    state_d    = i_last ? ST_IDLE : ST_REG;
                end else begin
                    state_d = ST_REG;
                end
            end
            ST_DATA: begin
                ready_s = data_can_s;
                if (i_valid && data_can_s) begin
                    data_ld_s = 1'b1;
                    cnt_d     = cnt_inc_s;
                    if (i_last) begin
                        data_last_s = 1'b1;
                        data_err_s  = i_err;
                        state_d     = ST_IDLE;
                    end else if (cnt_inc_s == MAX_WORDS) begin
                        // Oversized payload: close the stream with an error and discard the rest.
                        data_last_s = 1'b1;
                        data_err_s  = 1'b1;
                        state_d     = ST_DROP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DROP: begin
                ready_s = 1'b1;
                if (i_valid && i_last) begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, payload counter and drop pulse.
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {(LGMAXDATA+1){1'b0}};
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Register-stream output stage.
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            reg_valid_q <= 1'b0;
            reg_data_q  <= 32'h0000_0000;
            reg_last_q  <= 1'b0;
            reg_err_q   <= 1'b0;
        end else if (reg_ld_s) begin
            reg_valid_q <= 1'b1;
            reg_data_q  <= i_data;
            reg_last_q  <= reg_last_s;
            reg_err_q   <= reg_err_s;
        end else if (i_reg_ready) begin
            reg_valid_q <= 1'b0;
            if (OPT_LOWPOWER) begin
                reg_data_q <= 32'h0000_0000;
                reg_last_q <= 1'b0;
                reg_err_q  <= 1'b0;
            end
        end
    end

    // Data-stream output stage.
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            data_valid_q <= 1'b0;
            data_data_q  <= 32'h0000_0000;
            data_last_q  <= 1'b0;
            data_err_q   <= 1'b0;
        end else if (data_ld_s) begin
            data_valid_q <= 1'b1;
            data_data_q  <= i_data;
            data_last_q  <= data_last_s;
            data_err_q   <= data_err_s;
        end else if (i_data_ready) begin
            data_valid_q <= 1'b0;
            if (OPT_LOWPOWER) begin
                data_data_q <= 32'h0000_0000;
                data_last_q <= 1'b0;
                data_err_q  <= 1'b0;
            end
        end
    end

    assign o_ready      = ready_s;
    assign o_reg_valid  = reg_valid_q;
    assign o_reg_data   = reg_data_q;
    assign o_reg_last   = reg_last_q;
    assign o_reg_err    = reg_err_q;
    assign o_data_valid = data_valid_q;
    assign o_data_data  = data_data_q;
    assign o_data_last  = data_last_q;
    assign o_data_err   = data_err_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_satatrn_rxarb.sv
// Directed self-checking bench for satatrn_rxarb: routing, length limit, drop pulses,
// back-pressure and asynchronous reset recovery.
module tb_satatrn_rxarb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_last = 1'b0, i_err = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        o_ready;
    logic        o_reg_valid, o_reg_last, o_reg_err;
    logic        i_reg_ready = 1'b1;
    logic [31:0] o_reg_data;
    logic        o_data_valid, o_data_last, o_data_err;
    logic        i_data_ready = 1'b1;
    logic [31:0] o_data_data;
    logic        o_drop;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] reg_q[$];
    logic [33:0] data_q[$];
    int          drop_cnt = 0;
    int          reg_seen = 0;
    int          data_seen = 0;
    logic        bp_chk = 1'b0;
    logic        bp_toggle = 1'b0;
    logic [31:0] fis_mem [0:2100];

    satatrn_rxarb dut (
        .i_phy_clk     (clk),
        .i_phy_reset_n (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_last        (i_last),
        .i_err         (i_err),
        .o_reg_valid   (o_reg_valid),
        .i_reg_ready   (i_reg_ready),
        .o_reg_data    (o_reg_data),
        .o_reg_last    (o_reg_last),
        .o_reg_err     (o_reg_err),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
        .o_data_data   (o_data_data),
        .o_data_last   (o_data_last),
        .o_data_err    (o_data_err),
        .o_drop        (o_drop)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: records accepted beats and drop pulses mid-cycle.
    always @(negedge clk) begin
        if (o_reg_valid) reg_seen++;
        if (o_data_valid) data_seen++;
        if (o_reg_valid && i_reg_ready) reg_q.push_back({o_reg_err, o_reg_last, o_reg_data});
        if (o_data_valid && i_data_ready) data_q.push_back({o_data_err, o_data_last, o_data_data});
        if (o_drop) drop_cnt++;
        if (o_reg_valid && o_data_valid) check_eq("both_valid", 32'd1, 32'd0);
        if (bp_chk) check_eq("bp_ready", {31'd0, o_ready}, {31'd0, !(o_data_valid && !i_data_ready)});
    end

    // Data sink that alternates ready every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_toggle) i_data_ready = ~i_data_ready;
        end
    end

    task automatic clear_mon();
        reg_q.delete();
        data_q.delete();
        drop_cnt  = 0;
        reg_seen  = 0;
        data_seen = 0;
    endtask

    task automatic send_fis(input int n, input logic err, input logic term, input logic bp);
        logic acc;
        int   budget;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = fis_mem[k];
            i_last  = term && (k == n - 1);
            i_err   = err && i_last;
            acc     = 1'b0;
            budget  = 0;
            while (!acc && budget < 100) begin
                @(negedge clk);
                acc = o_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                check_eq("accept_timeout", 32'd0, 32'd1);
                break;
            end
            if (bp && k == 0) bp_chk = 1'b1;
        end
        bp_chk  = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_err   = 1'b0;
        i_data  = 32'h0;
    endtask

    initial begin
        logic [33:0] b;
        int          nlast;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_reg_valid", {31'd0, o_reg_valid}, 32'd0);
        check_eq("rst_data_valid", {31'd0, o_data_valid}, 32'd0);
        check_eq("rst_drop", {31'd0, o_drop}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Register FIS, 5 words
        clear_mon();
        fis_mem[0] = 32'h00A5_0034;
        for (int i = 1; i < 5; i++) fis_mem[i] = 32'h1000_0000 + i;
        send_fis(5, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("reg5_count", reg_q.size(), 32'd5);
        if (reg_q.size() == 5) begin
            check_eq("reg5_w0", reg_q[0][31:0], 32'h00A5_0034);
            check_eq("reg5_w4", reg_q[4][31:0], 32'h1000_0004);
            check_eq("reg5_last4", {31'd0, reg_q[4][32]}, 32'd1);
            check_eq("reg5_last3", {31'd0, reg_q[3][32]}, 32'd0);
            check_eq("reg5_err", {31'd0, reg_q[4][33]}, 32'd0);
        end
        check_eq("reg5_no_data", data_seen, 32'd0);

        // DATA FIS, 4 payload words, error on last
        clear_mon();
        fis_mem[0] = 32'h0000_0046;
        for (int i = 0; i < 4; i++) fis_mem[i+1] = 32'hA0 + i;
        send_fis(5, 1'b1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("d4_count", data_q.size(), 32'd4);
        for (int i = 0; i < data_q.size() && i < 4; i++) begin
            check_eq("d4_word", data_q[i][31:0], 32'hA0 + i);
            check_eq("d4_last", {31'd0, data_q[i][32]}, (i == 3) ? 32'd1 : 32'd0);
            check_eq("d4_err", {31'd0, data_q[i][33]}, (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("d4_no_reg", reg_seen, 32'd0);
        check_eq("d4_no_drop", drop_cnt, 32'd0);

        // Zero-payload DATA FIS, then a normal register FIS
        clear_mon();
        fis_mem[0] = 32'h0000_0046;
        send_fis(1, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("z_drop", drop_cnt, 32'd1);
        check_eq("z_no_valid", reg_seen + data_seen, 32'd0);
        clear_mon();
        fis_mem[0] = 32'h0000_0027;
        fis_mem[1] = 32'hCAFE_0001;
        send_fis(2, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("z_next_count", reg_q.size(), 32'd2);
        if (reg_q.size() == 2) check_eq("z_next_w1", reg_q[1][31:0], 32'hCAFE_0001);

        // Oversized DATA FIS: 2050 payload words
        clear_mon();
        fis_mem[0] = 32'h0000_0046;
        for (int i = 1; i <= 2050; i++) fis_mem[i] = 32'h0D00_0000 + i;
        send_fis(2051, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("big_count", data_q.size(), 32'd2048);
        nlast = 0;
        foreach (data_q[i]) if (data_q[i][32]) nlast++;
        check_eq("big_nlast", nlast, 32'd1);
        if (data_q.size() == 2048) begin
            b = data_q[2047];
            check_eq("big_w0", data_q[0][31:0], 32'h0D00_0001);
            check_eq("big_wlast", b[31:0], 32'h0D00_0800);
            check_eq("big_last", {31'd0, b[32]}, 32'd1);
            check_eq("big_err", {31'd0, b[33]}, 32'd1);
        end
        check_eq("big_drop", drop_cnt, 32'd1);
        check_eq("big_no_reg", reg_seen, 32'd0);

        // Back-pressure on the data sink, 8-word payload
        clear_mon();
        fis_mem[0] = 32'h0000_0046;
        for (int i = 1; i <= 8; i++) fis_mem[i] = 32'hB000_0000 + i;
        bp_toggle = 1'b1;
        send_fis(9, 1'b0, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        bp_toggle    = 1'b0;
        i_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_count", data_q.size(), 32'd8);
        for (int i = 0; i < data_q.size() && i < 8; i++)
            check_eq("bp_word", data_q[i][31:0], 32'hB000_0001 + i);
        if (data_q.size() == 8) check_eq("bp_last", {31'd0, data_q[7][32]}, 32'd1);

        // Asynchronous reset in the middle of a register FIS
        clear_mon();
        fis_mem[0] = 32'h0000_0034;
        fis_mem[1] = 32'h2222_0001;
        send_fis(2, 1'b0, 1'b0, 1'b0);
        i_reg_ready = 1'b0;
        @(negedge clk);
        check_eq("mid_valid_pre", {31'd0, o_reg_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_valid_rst", {31'd0, o_reg_valid}, 32'd0);
        check_eq("mid_dvalid_rst", {31'd0, o_data_valid}, 32'd0);
        i_reg_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        fis_mem[0] = 32'h0000_0039;
        fis_mem[1] = 32'h3333_0001;
        fis_mem[2] = 32'h3333_0002;
        send_fis(3, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_count", reg_q.size(), 32'd3);
        for (int i = 0; i < reg_q.size() && i < 3; i++) begin
            check_eq("post_rst_word", reg_q[i][31:0], fis_mem[i]);
            check_eq("post_rst_last", {31'd0, reg_q[i][32]}, (i == 2) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
